// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults, colour field layout and raster types
// for the VGA scan-out slice.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int CNT_W   = 10;
  localparam int COLOR_W = 12;
  localparam int R_HI    = 11;
  localparam int R_LO    = 8;
  localparam int G_HI    = 7;
  localparam int G_LO    = 4;
  localparam int B_HI    = 3;
  localparam int B_LO    = 0;

  typedef enum logic [0:0] {
    SCAN_WAIT = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } raster_t;

  localparam raster_t RASTER_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  function automatic logic [COLOR_W-1:0] bar_color(input logic [2:0] bar);
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    r = bar[2] ? 4'hF : 4'h0;
    g = bar[1] ? 4'hF : 4'h0;
    b = bar[0] ? 4'hF : 4'h0;
    return {r, g, b};
  endfunction

  // Column to bar number (0..7) for bars bar_w pixels wide.
  function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] x,
                                           input logic [CNT_W-1:0] bar_w);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({3'd0, x} >= (13'(k) * {3'd0, bar_w})) begin
        idx = 3'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to align raster flags with the
// upstream colour latency.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_r;

  // Shift one position per enabled tick; reset fills every stage with RST_VAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= RST_VAL;
      end
    end else if (en) begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_scan_out.sv
// VGA raster generator and pin driver: issues pixel coordinates upstream and
// drives latency-aligned sync/colour. Macro VGA_TEST_PATTERN_EN adds colour bars.
module vga_scan_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [11:0] vga_color,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_req,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  scan_state_t        state_r;
  logic [CNT_W-1:0]   h_cnt_r;
  logic [CNT_W-1:0]   v_cnt_r;
  logic [CNT_W-1:0]   h_nxt_s;
  logic [CNT_W-1:0]   v_nxt_s;
  logic               act_nxt_s;
  raster_t            raster_nxt_s;
  raster_t            raster_dly_s;
  logic [COLOR_W-1:0] src_color_s;

  // Next raster position; the first tick after reset lands on (0,0).
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    case (state_r)
      SCAN_WAIT: begin
        h_nxt_s = CNT_ZERO;
        v_nxt_s = CNT_ZERO;
      end
      SCAN_RUN: begin
        if (h_cnt_r == H_LAST) begin
          h_nxt_s = CNT_ZERO;
          if (v_cnt_r == V_LAST) begin
            v_nxt_s = CNT_ZERO;
          end else begin
            v_nxt_s = v_cnt_r + CNT_ONE;
          end
        end else begin
          h_nxt_s = h_cnt_r + CNT_ONE;
          v_nxt_s = v_cnt_r;
        end
      end
      default: begin
        h_nxt_s = CNT_ZERO;
        v_nxt_s = CNT_ZERO;
      end
    endcase
  end

  assign act_nxt_s    = (h_nxt_s < H_ACT) && (v_nxt_s < V_ACT);
  assign raster_nxt_s = '{active: act_nxt_s,
                          hs: !((h_nxt_s >= HS_FIRST) && (h_nxt_s <= HS_LAST)),
                          vs: !((v_nxt_s >= VS_FIRST) && (v_nxt_s <= VS_LAST))};

  vga_delay_line #(
    .WIDTH   ($bits(raster_t)),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (RASTER_IDLE)
  ) u_raster_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .din  (raster_nxt_s),
    .dout (raster_dly_s)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

  logic [2:0] bar_nxt_s;
  logic [2:0] bar_dly_s;

  assign bar_nxt_s = act_nxt_s ? bar_index(h_nxt_s, BAR_W) : 3'd0;

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_LAT),
    .RST_VAL (3'd0)
  ) u_bar_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .din  (bar_nxt_s),
    .dout (bar_dly_s)
  );

  assign src_color_s = test_pattern ? bar_color(bar_dly_s) : vga_color;
`else
  assign src_color_s = vga_color;
`endif

  // Raster counters plus the coordinate/frame outputs handed upstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= SCAN_WAIT;
      h_cnt_r     <= CNT_ZERO;
      v_cnt_r     <= CNT_ZERO;
      pixel_x     <= CNT_ZERO;
      pixel_y     <= CNT_ZERO;
      pixel_req   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        state_r     <= SCAN_RUN;
        h_cnt_r     <= h_nxt_s;
        v_cnt_r     <= v_nxt_s;
        pixel_req   <= act_nxt_s;
        pixel_x     <= act_nxt_s ? h_nxt_s : CNT_ZERO;
        pixel_y     <= act_nxt_s ? v_nxt_s : CNT_ZERO;
        frame_start <= (h_nxt_s == CNT_ZERO) && (v_nxt_s == CNT_ZERO);
      end
    end
  end

  // Sync and colour leave together from the delayed raster tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
    end else if (pix_en) begin
      vga_hs <= raster_dly_s.hs;
      vga_vs <= raster_dly_s.vs;
      vga_r  <= raster_dly_s.active ? src_color_s[R_HI:R_LO] : 4'h0;
      vga_g  <= raster_dly_s.active ? src_color_s[G_HI:G_LO] : 4'h0;
      vga_b  <= raster_dly_s.active ? src_color_s[B_HI:B_LO] : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// Directed self-checking bench for vga_scan_out: default 640x480 instance plus
// a tiny-timing instance so full frames fit in a short run.
module tb_vga_scan_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [11:0] vga_color;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_pattern;
`endif

  logic [9:0] pixel_x, pixel_y, s_pixel_x, s_pixel_y;
  logic       pixel_req, frame_start, vga_hs, vga_vs;
  logic       s_pixel_req, s_frame_start, s_vga_hs, s_vga_vs;
  logic [3:0] vga_r, vga_g, vga_b, s_vga_r, s_vga_g, s_vga_b;
  logic [11:0] rgb;

  int total = 0;
  int bad = 0;

  assign rgb = {vga_r, vga_g, vga_b};

  always #5 clk = ~clk;

  vga_scan_out dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vga_color(vga_color),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_req(pixel_req),
    .frame_start(frame_start), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  // Frame: 16 ticks/line (8 active, hs 10..12), 8 lines (4 active, vs 5..6).
  vga_scan_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_LAT(2)
  ) dut_small (
    .clk(clk), .rst(rst), .pix_en(pix_en), .vga_color(vga_color),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .pixel_x(s_pixel_x), .pixel_y(s_pixel_y), .pixel_req(s_pixel_req),
    .frame_start(s_frame_start), .vga_hs(s_vga_hs), .vga_vs(s_vga_vs),
    .vga_r(s_vga_r), .vga_g(s_vga_g), .vga_b(s_vga_b)
  );

  task automatic do_tick();
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (pixel_x !== 10'd0) begin bad++; $display("FAIL reset_x got=%0d want=0", pixel_x); end
    total++; if (pixel_y !== 10'd0) begin bad++; $display("FAIL reset_y got=%0d want=0", pixel_y); end
    total++; if (pixel_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", pixel_req); end
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b want=0", frame_start); end
    total++; if ({vga_hs, vga_vs} !== 2'b11) begin bad++; $display("FAIL reset_sync got=%b want=11", {vga_hs, vga_vs}); end
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h want=000", rgb); end
  endtask

  task automatic test_line_timing();
    int first_low, second_low, low_cnt, fs_cnt, coord_err, rgb_err, vs_err, bad_t;
    int h, v, dh, dv;
    logic exp_req;
    logic [9:0] ex, ey;
    logic [11:0] exp_rgb;
    first_low = -1; second_low = -1; low_cnt = 0; fs_cnt = 0;
    coord_err = 0; rgb_err = 0; vs_err = 0; bad_t = -1;
    apply_reset();
    vga_color = 12'hABC;
    for (int t = 0; t < 1600; t++) begin
      do_tick();
      h = t % 800; v = t / 800;
      exp_req = (h < 640) && (v < 480);
      ex = exp_req ? 10'(h) : 10'd0;
      ey = exp_req ? 10'(v) : 10'd0;
      if (pixel_req !== exp_req || pixel_x !== ex || pixel_y !== ey) begin
        if (coord_err == 0) bad_t = t;
        coord_err++;
      end
      exp_rgb = 12'h000;
      if (t >= 2) begin
        dh = (t - 2) % 800; dv = (t - 2) / 800;
        if (dh < 640 && dv < 480) exp_rgb = 12'hABC;
      end
      if (rgb !== exp_rgb) rgb_err++;
      if (vga_vs !== 1'b1) vs_err++;
      if (frame_start === 1'b1) fs_cnt++;
      if (vga_hs === 1'b0) begin
        if (first_low < 0) first_low = t;
        if (t < 1458) low_cnt++;
        if (t >= 800 && second_low < 0) second_low = t;
      end
      if (t == 0) begin
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL first_tick_fs got=%b want=1", frame_start); end
        total++; if ({pixel_req, pixel_x, pixel_y} !== 21'h100000) begin bad++; $display("FAIL first_tick_coord got=%b/%0d/%0d want=1/0/0", pixel_req, pixel_x, pixel_y); end
      end
      if (t == 1) begin
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL tick1_rgb got=%h want=000", rgb); end
      end
      if (t == 2) begin
        total++; if (rgb !== 12'hABC) begin bad++; $display("FAIL tick2_rgb got=%h want=abc", rgb); end
      end
      repeat (3) @(negedge clk);
      if (t == 0) begin
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL fs_width got=%b want=0", frame_start); end
      end
      if (t == 5) begin
        total++; if (pixel_x !== 10'd5) begin bad++; $display("FAIL hold_no_tick got=%0d want=5", pixel_x); end
      end
    end
    total++; if (first_low !== 658) begin bad++; $display("FAIL hs_first_low got=%0d want=658", first_low); end
    total++; if (low_cnt !== 96) begin bad++; $display("FAIL hs_width got=%0d want=96", low_cnt); end
    total++; if (second_low !== 1458) begin bad++; $display("FAIL hs_period got=%0d want=1458", second_low); end
    total++; if (coord_err !== 0) begin bad++; $display("FAIL coord_errors got=%0d want=0 first_tick=%0d", coord_err, bad_t); end
    total++; if (rgb_err !== 0) begin bad++; $display("FAIL const_rgb_errors got=%0d want=0", rgb_err); end
    total++; if (vs_err !== 0) begin bad++; $display("FAIL vs_early got=%0d want=0", vs_err); end
    total++; if (fs_cnt !== 1) begin bad++; $display("FAIL fs_count_line got=%0d want=1", fs_cnt); end
  endtask

  // Upstream model: colour for a coordinate arrives two ticks after it is issued.
  task automatic test_upstream();
    logic [9:0] p1x, p1y, p2x, p2y;
    logic [11:0] exp_rgb;
    int d, dh, dv, err, act_cnt;
    p1x = 10'd0; p1y = 10'd0; p2x = 10'd0; p2y = 10'd0;
    err = 0; act_cnt = 0;
    apply_reset();
    for (int t = 0; t <= 1100; t++) begin
      vga_color = {p2x[3:0], p2y[3:0], 4'h5};
      do_tick();
      exp_rgb = 12'h000;
      if (t >= 2) begin
        d = t - 2; dh = d % 800; dv = d / 800;
        if (dh < 640 && dv < 480) begin
          exp_rgb = {dh[3:0], dv[3:0], 4'h5};
          act_cnt++;
        end
      end
      if (rgb !== exp_rgb) begin
        if (err == 0) $display("FAIL upstream_pixel tick=%0d got=%h want=%h", t, rgb, exp_rgb);
        err++;
      end
      p2x = p1x; p2y = p1y;
      p1x = pixel_x; p1y = pixel_y;
    end
    total++; if (err !== 0) begin bad++; $display("FAIL upstream_errors got=%0d want=0", err); end
    total++; if (act_cnt !== 1099 - 160) begin bad++; $display("FAIL upstream_active got=%0d want=939", act_cnt); end
  endtask

  // Counters sit at (300,1) from the previous task when reset hits.
  task automatic test_reset_mid();
    vga_color = 12'hFFF;
    total++; if (pixel_x !== 10'd300 || pixel_y !== 10'd1) begin bad++; $display("FAIL pre_reset_pos got=%0d,%0d want=300,1", pixel_x, pixel_y); end
    #2; rst = 1'b1; #1;
    test_reset();
    @(negedge clk); rst = 1'b0; @(negedge clk);
    do_tick();
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL restart_fs got=%b want=1", frame_start); end
    total++; if ({pixel_req, pixel_x, pixel_y} !== 21'h100000) begin bad++; $display("FAIL restart_coord got=%b/%0d/%0d want=1/0/0", pixel_req, pixel_x, pixel_y); end
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL restart_rgb0 got=%h want=000", rgb); end
    do_tick();
    total++; if (rgb !== 12'h000) begin bad++; $display("FAIL restart_rgb1 got=%h want=000", rgb); end
    do_tick();
    total++; if (rgb !== 12'hFFF) begin bad++; $display("FAIL restart_rgb2 got=%h want=fff", rgb); end
  endtask

  task automatic test_frame_small();
    int fs_cnt, fs_pos_err, vs_low, first_vs;
    fs_cnt = 0; fs_pos_err = 0; vs_low = 0; first_vs = -1;
    apply_reset();
    for (int t = 0; t < 300; t++) begin
      do_tick();
      if (s_frame_start === 1'b1) begin
        fs_cnt++;
        if (t % 128 != 0) fs_pos_err++;
      end
      if (s_vga_vs === 1'b0 && t < 128) begin
        vs_low++;
        if (first_vs < 0) first_vs = t;
      end
      if (t == 55) begin
        total++; if ({s_pixel_req, s_pixel_x, s_pixel_y} !== {1'b1, 10'd7, 10'd3}) begin bad++; $display("FAIL small_last_active got=%b/%0d/%0d want=1/7/3", s_pixel_req, s_pixel_x, s_pixel_y); end
      end
      if (t == 56) begin
        total++; if ({s_pixel_req, s_pixel_x} !== 11'd0) begin bad++; $display("FAIL small_fp got=%b/%0d want=0/0", s_pixel_req, s_pixel_x); end
      end
      if (t == 128) begin
        total++; if ({s_pixel_req, s_pixel_x, s_pixel_y} !== 21'h100000) begin bad++; $display("FAIL small_wrap got=%b/%0d/%0d want=1/0/0", s_pixel_req, s_pixel_x, s_pixel_y); end
      end
    end
    total++; if (fs_cnt !== 3) begin bad++; $display("FAIL small_fs_count got=%0d want=3", fs_cnt); end
    total++; if (fs_pos_err !== 0) begin bad++; $display("FAIL small_fs_pos got=%0d want=0", fs_pos_err); end
    total++; if (vs_low !== 32) begin bad++; $display("FAIL small_vs_width got=%0d want=32", vs_low); end
    total++; if (first_vs !== 82) begin bad++; $display("FAIL small_vs_start got=%0d want=82", first_vs); end
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern_bars();
    int x, err;
    logic [11:0] exp_rgb;
    err = 0;
    apply_reset();
    test_pattern = 1'b1;
    vga_color = 12'h123;
    for (int t = 0; t < 642; t++) begin
      do_tick();
      if (t >= 2) begin
        x = t - 2;
        exp_rgb = rgb;
        if (x < 80) exp_rgb = 12'h000;
        else if (x < 160) exp_rgb = 12'h00F;
        else if (x >= 560) exp_rgb = 12'hFFF;
        if ((x < 160 || x >= 560) && rgb !== exp_rgb) begin
          if (err == 0) $display("FAIL bar_pixel x=%0d got=%h want=%h", x, rgb, exp_rgb);
          err++;
        end
      end
    end
    total++; if (err !== 0) begin bad++; $display("FAIL bar_errors got=%0d want=0", err); end
    test_pattern = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b0;
    pix_en = 1'b0;
    vga_color = 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_line_timing();
    test_upstream();
    test_reset_mid();
    test_frame_small();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern_bars();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
